// File: rtl/dram_axi_pkg.sv
// Shared constants and types for the DRAM reader/writer AXI3 masters.
package dram_axi_pkg;

    // Burst shape: 16 beats of 8 bytes, 128 bytes per burst.
    localparam int BURST_BEATS = 16;
    localparam int BURST_BYTES = 128;
    localparam int BEAT_BYTES  = 8;

    // Fixed AXI burst attributes.
    localparam logic [3:0] AXI_LEN        = 4'b1111;
    localparam logic [1:0] AXI_SIZE       = 2'b11;
    localparam logic [1:0] AXI_BURST_INCR = 2'b01;

    // Response codes.
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef enum logic {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } fsm_state_e;

    // Number of whole bursts in a byte count; sub-burst remainder is dropped.
    function automatic logic [24:0] bursts_of(input logic [31:0] nbytes);
        return nbytes[31:7];
    endfunction

endpackage

// File: rtl/axi_skid_buffer.sv
// Two-entry valid/ready buffer with a registered input ready. in_ready_o
// means "at least one entry is free this cycle" and is computed one cycle
// ahead, so nothing on the output side reaches it combinationally.
module axi_skid_buffer #(
    parameter int DATA_W = 64
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [DATA_W-1:0] in_data_i,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic              accept_en_i,
    output logic [DATA_W-1:0] out_data_o,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic              empty_o
);

    logic [DATA_W-1:0] mem_q [2];
    logic [1:0]        count_q, count_d;
    logic              wr_ptr_q, wr_ptr_d;
    logic              rd_ptr_q, rd_ptr_d;
    logic              rdy_q, rdy_d;
    logic              push, pop;

    // Occupancy bookkeeping and next-cycle ready (accept_en_i gates it off).
    always_comb begin
        push     = in_valid_i && rdy_q;
        pop      = (count_q != 2'd0) && out_ready_i;
        count_d  = count_q;
        wr_ptr_d = wr_ptr_q ^ push;
        rd_ptr_d = rd_ptr_q ^ pop;
        case ({push, pop})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase
        rdy_d = accept_en_i && (count_d != 2'd2);
    end

    // Control state: pointers, count and registered ready.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            count_q  <= 2'd0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            rdy_q    <= 1'b0;
        end else begin
            count_q  <= count_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            rdy_q    <= rdy_d;
        end
    end

    // Data storage; contents are qualified by count_q so no reset needed.
    always_ff @(posedge clk_i) begin
        if (push) begin
            mem_q[wr_ptr_q] <= in_data_i;
        end
    end

    assign in_ready_o  = rdy_q;
    assign out_valid_o = (count_q != 2'd0);
    assign out_data_o  = mem_q[rd_ptr_q];
    assign empty_o     = (count_q == 2'd0);

endmodule

// File: rtl/dram_reader.sv
// AXI3 read master: streams a contiguous, 128-byte aligned DRAM region as
// 16-beat INCR bursts onto a 64-bit valid/ready port, with a cap on bursts
// in flight and a sticky error flag for bad responses or misplaced RLAST.
module dram_reader
    import dram_axi_pkg::*;
#(
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic        ACLK,
    input  logic        ARESET,
    output logic [31:0] M_AXI_ARADDR,
    output logic        M_AXI_ARVALID,
    input  logic        M_AXI_ARREADY,
    output logic [3:0]  M_AXI_ARLEN,
    output logic [1:0]  M_AXI_ARSIZE,
    output logic [1:0]  M_AXI_ARBURST,
    input  logic [63:0] M_AXI_RDATA,
    input  logic [1:0]  M_AXI_RRESP,
    input  logic        M_AXI_RLAST,
    input  logic        M_AXI_RVALID,
    output logic        M_AXI_RREADY,
    input  logic        CONFIG_VALID,
    output logic        CONFIG_READY,
    input  logic [31:0] CONFIG_START_ADDR,
    input  logic [31:0] CONFIG_NBYTES,
    output logic [63:0] DATA,
    output logic        DATA_VALID,
    input  logic        DATA_READY,
    output logic        ERROR
);

    localparam logic [3:0] MAX_OS    = 4'(MAX_OUTSTANDING);
    localparam logic [3:0] LAST_BEAT = 4'(BURST_BEATS - 1);

    fsm_state_e  a_state_q, a_state_d;
    fsm_state_e  r_state_q, r_state_d;
    logic [31:0] araddr_q, araddr_d;
    logic [24:0] a_count_q, a_count_d;
    logic [24:0] r_bursts_q, r_bursts_d;
    logic [3:0]  beat_cnt_q, beat_cnt_d;
    logic [3:0]  outstanding_q, outstanding_d;
    logic        error_q, error_d;

    logic        cfg_fire, ar_fire, r_fire, r_last_beat, skid_empty;
    logic [24:0] cfg_bursts;
    logic        unused_nbytes_low;

    assign unused_nbytes_low = ^CONFIG_NBYTES[6:0];

    assign cfg_bursts    = bursts_of(CONFIG_NBYTES);
    assign CONFIG_READY  = (a_state_q == IDLE) && (r_state_q == IDLE) && skid_empty;
    assign cfg_fire      = CONFIG_VALID && CONFIG_READY;
    // The gate can only lower ARVALID before it rises: outstanding never
    // grows while an address is waiting for ARREADY.
    assign M_AXI_ARVALID = (a_state_q == ACTIVE) && (outstanding_q < MAX_OS);
    assign ar_fire       = M_AXI_ARVALID && M_AXI_ARREADY;
    assign r_fire        = M_AXI_RVALID && M_AXI_RREADY;
    assign r_last_beat   = (beat_cnt_q == LAST_BEAT);

    assign M_AXI_ARADDR  = araddr_q;
    assign M_AXI_ARLEN   = AXI_LEN;
    assign M_AXI_ARSIZE  = AXI_SIZE;
    assign M_AXI_ARBURST = AXI_BURST_INCR;
    assign ERROR         = error_q;

    // Address FSM: load on config, then step 128 bytes per accepted AR.
    always_comb begin
        a_state_d = a_state_q;
        araddr_d  = araddr_q;
        a_count_d = a_count_q;
        case (a_state_q)
            IDLE: begin
                if (cfg_fire) begin
                    araddr_d  = CONFIG_START_ADDR;
                    a_count_d = cfg_bursts;
                    if (cfg_bursts != 25'd0) begin
                        a_state_d = ACTIVE;
                    end
                end
            end
            ACTIVE: begin
                if (ar_fire) begin
                    araddr_d  = araddr_q + 32'(BURST_BYTES);
                    a_count_d = a_count_q - 25'd1;
                    if (a_count_q == 25'd1) begin
                        a_state_d = IDLE;
                    end
                end
            end
            default: a_state_d = IDLE;
        endcase
    end

    // Read FSM: count beats; finish on the final beat of the final burst.
    always_comb begin
        r_state_d  = r_state_q;
        r_bursts_d = r_bursts_q;
        beat_cnt_d = beat_cnt_q;
        if (cfg_fire) begin
            r_bursts_d = cfg_bursts;
            beat_cnt_d = 4'd0;
            if (cfg_bursts != 25'd0) begin
                r_state_d = ACTIVE;
            end
        end else if ((r_state_q == ACTIVE) && r_fire) begin
            beat_cnt_d = beat_cnt_q + 4'd1;
            if (r_last_beat) begin
                r_bursts_d = r_bursts_q - 25'd1;
                if (r_bursts_q == 25'd1) begin
                    r_state_d = IDLE;
                end
            end
        end
    end

    // In-flight burst count and sticky error flag.
    always_comb begin
        outstanding_d = outstanding_q;
        error_d       = error_q;
        if (cfg_fire) begin
            // Previous transfer has fully drained; start from a clean count.
            outstanding_d = 4'd0;
            error_d       = 1'b0;
        end else begin
            if (ar_fire && !(r_fire && M_AXI_RLAST)) begin
                outstanding_d = outstanding_q + 4'd1;
            end else if (!ar_fire && r_fire && M_AXI_RLAST && (outstanding_q != 4'd0)) begin
                // Spurious RLASTs must not wrap the count and stall issue.
                outstanding_d = outstanding_q - 4'd1;
            end
            if (r_fire && ((M_AXI_RRESP != RESP_OKAY) || (M_AXI_RLAST != r_last_beat))) begin
                error_d = 1'b1;
            end
        end
    end

    // State, counter and flag registers.
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            a_state_q     <= IDLE;
            r_state_q     <= IDLE;
            araddr_q      <= 32'd0;
            a_count_q     <= 25'd0;
            r_bursts_q    <= 25'd0;
            beat_cnt_q    <= 4'd0;
            outstanding_q <= 4'd0;
            error_q       <= 1'b0;
        end else begin
            a_state_q     <= a_state_d;
            r_state_q     <= r_state_d;
            araddr_q      <= araddr_d;
            a_count_q     <= a_count_d;
            r_bursts_q    <= r_bursts_d;
            beat_cnt_q    <= beat_cnt_d;
            outstanding_q <= outstanding_d;
            error_q       <= error_d;
        end
    end

    axi_skid_buffer #(
        .DATA_W (BEAT_BYTES * 8)
    ) u_skid (
        .clk_i       (ACLK),
        .rst_i       (ARESET),
        .in_data_i   (M_AXI_RDATA),
        .in_valid_i  (M_AXI_RVALID),
        .in_ready_o  (M_AXI_RREADY),
        .accept_en_i (r_state_d == ACTIVE),
        .out_data_o  (DATA),
        .out_valid_o (DATA_VALID),
        .out_ready_i (DATA_READY),
        .empty_o     (skid_empty)
    );

endmodule

// File: doc/dram_reader.md
Name: dram_reader

Overview:
- AXI3 read master that streams a contiguous DRAM region onto a 64-bit valid/ready data port.
- It is the read-side counterpart of the DRAM writer and uses the same config handshake and burst shape: 16-beat INCR bursts of 8 bytes per beat, so each burst covers 128 bytes.
- It limits the number of outstanding bursts, checks response integrity, and decouples R-channel backpressure from the downstream consumer through a registered skid buffer.

Parameters:
- MAX_OUTSTANDING, 4, maximum number of AR bursts issued whose RLAST has not yet been accepted (1..15).

Ports:
- ACLK  in  1  clock; all logic on rising edge.
- ARESET  in  1  synchronous active-high reset.
- M_AXI_ARADDR  out  32  burst address.
- M_AXI_ARVALID  out  1  address valid.
- M_AXI_ARREADY  in  1  address accepted.
- M_AXI_ARLEN  out  4  constant 4'b1111.
- M_AXI_ARSIZE  out  2  constant 2'b11.
- M_AXI_ARBURST  out  2  constant 2'b01 (INCR).
- M_AXI_RDATA  in  64  read data.
- M_AXI_RRESP  in  2  read response.
- M_AXI_RLAST  in  1  last beat of burst.
- M_AXI_RVALID  in  1  read data valid.
- M_AXI_RREADY  out  1  read data ready.
- CONFIG_VALID  in  1  start request.
- CONFIG_READY  out  1  block idle, config acceptable.
- CONFIG_START_ADDR  in  32  byte address; must be 128-byte aligned.
- CONFIG_NBYTES  in  32  byte count; bits [6:0] ignored.
- DATA  out  64  stream data.
- DATA_VALID  out  1  stream valid.
- DATA_READY  in  1  stream ready.
- ERROR  out  1  sticky error flag.

Behaviour:
- Reset (ARESET=1 at a clock edge):
  - Both FSMs go to IDLE; all counters clear; skid buffer empties.
  - ARVALID=0, ARADDR=0, DATA_VALID=0, ERROR=0, RREADY=0.
  - CONFIG_READY=1 from the first cycle after reset deasserts.
  - Reset mid-transfer abandons the transfer. The interconnect must be reset alongside this block, because stale R beats are not drained.
- Config acceptance:
  - Accepted on an edge where CONFIG_VALID && CONFIG_READY.
  - CONFIG_READY = (a_state==IDLE) && (r_state==IDLE) && skid empty.
  - On accept:
    - ARADDR <= START_ADDR.
    - a_count <= NBYTES[31:7].
    - r_bursts <= NBYTES[31:7].
    - beat_cnt <= 0.
    - ERROR <= 0.
  - If NBYTES[31:7]==0, both FSMs stay IDLE, no AXI traffic is issued, and CONFIG_READY stays 1.
- Address FSM (IDLE, ISSUE):
  - ARVALID = (a_state==ISSUE) && (outstanding < MAX_OUTSTANDING).
  - On ARVALID && ARREADY: ARADDR += 128 and a_count -= 1. When a_count becomes 0, go to IDLE.
  - ARADDR and ARVALID are held stable while ARVALID && !ARREADY. The outstanding gate may only drop ARVALID before assertion, never while waiting for ARREADY.
  - ARADDR wraps modulo 2^32 with no special handling.
- Outstanding counter (4 bits):
  - +1 on an AR handshake.
  - −1 on an R handshake with RLAST.
  - Both events in the same cycle leave it unchanged.
- Read FSM (IDLE, RECV):
  - Enters RECV on config accept when the burst count is nonzero.
  - Each R handshake (RVALID && RREADY):
    - The beat is pushed into the skid buffer.
    - beat_cnt increments, 4 bits, wrapping 15→0.
  - On the beat where beat_cnt==15, r_bursts decrements. When it reaches 0, go to IDLE.
  - The read FSM ends on beat count only; RLAST is not used for termination.
- Error detection (ERROR is sticky until the next config accept):
  - Set on an R handshake where RRESP != 2'b00.
  - Set on an R handshake where RLAST != (beat_cnt==15).
  - Errored data is still forwarded.
- Skid buffer:
  - 2 entries; RREADY is a register meaning "at least one free entry next cycle".
  - No combinational path from DATA_READY to RREADY.
  - Minimum latency is 1 cycle: a beat accepted at edge t is on DATA with DATA_VALID after edge t.
  - Full throughput of 1 beat/cycle is sustained while DATA_READY=1.
  - Push and pop in the same cycle preserve order.
  - Full: RREADY=0. Empty: DATA_VALID=0.
  - RREADY=0 whenever r_state==IDLE.

Decomposition:
- Shared package dram_axi_pkg holds:
  - BURST_BEATS=16, BURST_BYTES=128, BEAT_BYTES=8.
  - The AXI LEN/SIZE/BURST constants (shared with the writer).
  - Response codes OKAY=0, SLVERR=2, DECERR=3.
  - An FSM state enum {IDLE, ACTIVE}.
- One sub-module, axi_skid_buffer: 2-entry, 64-bit data, valid/ready on both sides with registered in_ready.
- The AR FSM, R FSM, counters and error logic stay in dram_reader.

Test Plan:
- Basic transfer:
  - Stimulus: START_ADDR=0x1000_0000, NBYTES=256; slave returns an incrementing pattern with zero wait states; DATA_READY=1.
  - Required: two ARs at 0x1000_0000 and 0x1000_0080; 32 beats out in order; CONFIG_READY returns 1 after the last beat drains; ERROR=0.
- Outstanding limit:
  - Stimulus: NBYTES=1024 (8 bursts); slave accepts ARs immediately but delays R data by 50 cycles.
  - Required: exactly MAX_OUTSTANDING=4 ARs issued before the first RLAST; the 5th AR follows the first RLAST handshake.
- Backpressure:
  - Stimulus: NBYTES=128; DATA_READY toggles randomly, including 20 consecutive cycles low.
  - Required: no beat lost or duplicated; RREADY falls within 1 cycle of the skid filling; RREADY never depends combinationally on DATA_READY.
- Error cases (separate runs):
  - Stimulus: RRESP=SLVERR on beat 5 in one run; RLAST asserted on beat 14 in another.
  - Required: ERROR=1 from the cycle after the bad beat and held; the transfer still completes after 16 beats per burst; the next config accept clears ERROR.
- Zero length and no-op config:
  - Stimulus: NBYTES=0x7F.
  - Required: no ARVALID ever asserted; CONFIG_READY stays 1.
- Reset mid-operation:
  - Stimulus: NBYTES=512; ARESET asserted for 1 cycle after 20 beats.
  - Required: next cycle ARVALID=0, DATA_VALID=0, RREADY=0, CONFIG_READY=1; a fresh transfer then completes correctly.
